// File: rtl/wb_ram_slave_if.sv
// wb_ram_slave_if: Wishbone B4 classic bus bundle with master and slave views
interface wb_ram_slave_if;
   logic        CYC;
   logic        STB;
   logic        WE;
   logic [31:0] ADR;
   logic [31:0] DAT_O;
   logic [31:0] DAT_I;
   logic        ACK;
   logic        ERR;
   logic        RTY;
   modport master (output CYC, STB, WE, ADR, DAT_O, input DAT_I, ACK, ERR, RTY);
   modport slave  (input CYC, STB, WE, ADR, DAT_O, output DAT_I, ACK, ERR, RTY);
endinterface

// File: rtl/wb_ram_slave.sv
// wb_ram_slave: Wishbone B4 RAM slave with wait states; WB_RAM_SLAVE_ERR_EN answers out-of-range with ERR
module wb_ram_slave #(
   parameter int          DEPTH       = 256,
   parameter logic [31:0] ADR_BASE    = 32'h0000_1000,
   parameter int          WAIT_STATES = 2
) (
   input logic          clk,
   input logic          rst,
   wb_ram_slave_if.slave wb
);
   localparam int          AW   = $clog2(DEPTH);
   localparam logic [31:0] SPAN = 32'(DEPTH * 4);
`ifdef WB_RAM_SLAVE_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [31:0]    adr_q, wdat_q, rdat_q, rdat_d;
   logic           we_q;
   logic           req, hit, cur_we, enter_resp, resp;
   logic [31:0]    cur_adr, off;
   logic [AW-1:0]  idx;
   logic [31:0]    mem [DEPTH];
   assign req        = wb.CYC && wb.STB;
   // in IDLE the bus address is used directly so a zero-wait read can fetch data on the request edge
   assign cur_adr    = state_q == IDLE ? wb.ADR : adr_q;
   assign cur_we     = state_q == IDLE ? wb.WE : we_q;
   assign off        = cur_adr - ADR_BASE;
   assign idx        = off[AW+1:2];
   assign hit        = off < SPAN;
   assign enter_resp = state_d == RESP && state_q != RESP;
   assign resp       = state_q == RESP && wb.CYC;
   assign wb.ACK     = resp && (hit || !ERR_EN);
   assign wb.ERR     = resp && !hit && ERR_EN;
   assign wb.RTY     = 1'b0;
   assign wb.DAT_I   = rdat_q;
   // next state, wait counter and read data captured when entering RESP
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (req) begin
            state_d = WAIT_STATES == 0 ? RESP : WAIT;
            cnt_d   = WAIT_STATES == 0 ? 4'd0 : 4'(WAIT_STATES - 1);
         end
         WAIT: begin
            state_d = !wb.CYC ? IDLE : cnt_q == 4'd0 ? RESP : WAIT;
            cnt_d   = !wb.CYC || cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
      rdat_d = !enter_resp ? rdat_q :
               !hit        ? (cur_we && !ERR_EN ? rdat_q : 32'h0) :
               cur_we      ? rdat_q : mem[idx];
   end
   // state, counter, latched request and read data register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rdat_q  <= 32'h0;
         adr_q   <= 32'h0;
         wdat_q  <= 32'h0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdat_q  <= rdat_d;
         if (state_q == IDLE && req) begin
            adr_q  <= wb.ADR;
            we_q   <= wb.WE;
            wdat_q <= wb.DAT_O;
         end
      end
   end
   // RAM is never reset; a write lands only on the edge closing a live in-range response
   always_ff @(posedge clk) begin
      if (resp && we_q && hit) mem[idx] <= wdat_q;
   end
endmodule

// File: tb/tb_wb_ram_slave.sv
// tb_wb_ram_slave: randomized scoreboard bench for wb_ram_slave (2 and 0 wait states)
module tb_wb_ram_slave;
`ifdef WB_RAM_SLAVE_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   typedef struct {bit err; bit chk; logic [31:0] dat; int cyc;} exp_t;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, sel = 1'b0;
   logic [31:0] adr = 32'h0, dout = 32'h0;
   int          checks = 0, errors = 0, cyc_cnt = 0;
   exp_t        q[$];
   logic [31:0] mem_m [2][256];
   bit          known [2][256];
   logic [31:0] last [2];
   bit          lastk [2];
   wb_ram_slave_if ifa ();
   wb_ram_slave_if ifb ();
   assign ifa.CYC = cyc && !sel;
   assign ifa.STB = stb && !sel;
   assign ifa.WE = we;
   assign ifa.ADR = adr;
   assign ifa.DAT_O = dout;
   assign ifb.CYC = cyc && sel;
   assign ifb.STB = stb && sel;
   assign ifb.WE = we;
   assign ifb.ADR = adr;
   assign ifb.DAT_O = dout;
   wb_ram_slave #(.WAIT_STATES(2)) ua (.clk(clk), .rst(rst), .wb(ifa.slave));
   wb_ram_slave #(.WAIT_STATES(0)) ub (.clk(clk), .rst(rst), .wb(ifb.slave));
   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask
   // monitor: pops one expectation per response cycle of the selected slave
   always @(negedge clk) begin
      logic ack, err, rty, oack, oerr;
      logic [31:0] d;
      exp_t e;
      ack = sel ? ifb.ACK : ifa.ACK;
      err = sel ? ifb.ERR : ifa.ERR;
      rty = sel ? ifb.RTY : ifa.RTY;
      d = sel ? ifb.DAT_I : ifa.DAT_I;
      oack = sel ? ifa.ACK : ifb.ACK;
      oerr = sel ? ifa.ERR : ifb.ERR;
      if (oack || oerr) chk("idle_slave_resp", {30'h0, oack, oerr}, 32'h0);
      if (ack || err) begin
         if (q.size() == 0) chk("unexpected_resp", {30'h0, ack, err}, 32'h0);
         else begin
            e = q.pop_front();
            chk("resp_kind", {29'h0, ack, err, rty}, {29'h0, !e.err, e.err, 1'b0});
            chk("resp_cycle", 32'(cyc_cnt), 32'(e.cyc));
            if (e.chk) chk("resp_data", d, e.dat);
         end
      end
   end
   // reference model: byte offset from base, 1 KiB window, word index, access outcome
   task automatic model(input bit w, input logic [31:0] a, input logic [31:0] wd, input int c0, input int s);
      exp_t e;
      logic [31:0] off;
      int i;
      off = a - 32'h1000;
      i = int'(off / 4) % 256;
      e.cyc = c0;
      e.err = off >= 1024 && ERR_EN;
      if (off < 1024 && w) begin
         mem_m[s][i] = wd;
         known[s][i] = 1'b1;
      end else if (off < 1024) begin
         last[s] = mem_m[s][i];
         lastk[s] = known[s][i];
      end else if (!w || ERR_EN) begin
         last[s] = 32'h0;
         lastk[s] = 1'b1;
      end
      e.dat = last[s];
      e.chk = lastk[s];
      q.push_back(e);
   endtask
   // issue one request (call just after a rising edge); leaves CYC/STB high after the response
   task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] wd);
      int ws;
      ws = sel ? 0 : 2;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dout = wd;
      @(posedge clk); #1;
      model(w, a, wd, cyc_cnt + ws, int'(sel));
      repeat (ws + 1) @(posedge clk);
      #1;
   endtask
   task automatic idle(input int n);
      cyc = 1'b0; stb = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask
   initial begin
      for (int s = 0; s < 2; s++) begin
         last[s] = 32'h0;
         lastk[s] = 1'b1;
         for (int i = 0; i < 256; i++) known[s][i] = 1'b0;
      end
      #1;
      chk("reset_a", {ifa.ACK, ifa.ERR, ifa.RTY}, 3'b000);
      chk("reset_a_dat", ifa.DAT_I, 32'h0);
      chk("reset_b", {ifb.ACK, ifb.ERR, ifb.RTY, ifb.DAT_I}, 35'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      issue(1'b1, 32'h1004, 32'hDEADBEEF); idle(1);
      issue(1'b0, 32'h1004, 32'h0); idle(1);
      issue(1'b1, 32'h13FC, 32'hA5A5_0FF0); idle(1);
      issue(1'b0, 32'h13FC, 32'h0); idle(1);
      issue(1'b1, 32'h1400, 32'h1111_1111); idle(1);
      issue(1'b0, 32'h1400, 32'h0); idle(1);
      issue(1'b1, 32'h0FFC, 32'h2222_2222); idle(1);
      issue(1'b0, 32'h0FFC, 32'h0); idle(1);
      issue(1'b0, 32'h13FF, 32'h0); idle(1);
      issue(1'b1, 32'h1008, 32'hCAFE_F00D); idle(1);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h1008; dout = 32'h1234_5678;
      @(posedge clk); #1;
      idle(5);
      issue(1'b0, 32'h1008, 32'h0);
      issue(1'b0, 32'h1004, 32'h0);
      issue(1'b0, 32'h1008, 32'h0); idle(1);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h1004; dout = 32'h5555_AAAA;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("async_rst_resp", {ifa.ACK, ifa.ERR, ifa.RTY}, 3'b000);
      chk("async_rst_dat", ifa.DAT_I, 32'h0);
      cyc = 1'b0; stb = 1'b0;
      last[0] = 32'h0;
      lastk[0] = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      issue(1'b0, 32'h1004, 32'h0); idle(1);
      for (int k = 0; k < 40; k++) begin
         logic [31:0] a;
         a = $urandom_range(0, 4) == 0 ?
             ($urandom_range(0, 1) ? 32'h1000 - 32'(4 * $urandom_range(1, 8)) : 32'h1400 + 32'($urandom_range(0, 64))) :
             32'h1000 + 32'(4 * $urandom_range(0, 255)) + 32'($urandom_range(0, 3));
         issue(1'($urandom_range(0, 1)), a, $urandom);
         if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
      end
      idle(2);
      sel = 1'b1;
      issue(1'b1, 32'h1000, 32'h0BAD_CAFE); idle(1);
      issue(1'b0, 32'h1000, 32'h0);
      issue(1'b0, 32'h1000, 32'h0); idle(1);
      issue(1'b1, 32'h1400, 32'h1); idle(1);
      issue(1'b0, 32'h1000, 32'h0); idle(4);
      chk("queue_drained", 32'(q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule

// File: doc/wb_ram_slave.md
WB_RAM_SLAVE -- requirements
Module: wb_ram_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit words (power of two, 4..65536).
REQ-002 SHALL have parameter ADR_BASE, default 32'h0000_1000, meaning byte base address (aligned to DEPTH*4).
REQ-003 SHALL have parameter WAIT_STATES, default 2, meaning extra cycles before the response (0..15).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port wb  WB4 slave side  bundle  Wishbone B4 classic slave.
REQ-007 SHALL sample wb.CYC, wb.STB and wb.WE (1 bit each), wb.ADR (32, byte address) and wb.DAT_O (32, write data).
REQ-008 SHALL drive wb.DAT_I (32, read data) and wb.ACK, wb.ERR and wb.RTY (1 bit each).

Function
REQ-009 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-010 SHALL, in IDLE, on wb.CYC && wb.STB at a clock edge, latch ADR, WE and DAT_O.
REQ-011 SHALL, from IDLE, go to RESP if WAIT_STATES==0, else go to WAIT with the counter loaded to WAIT_STATES-1.
REQ-012 SHALL, in WAIT, decrement the counter each cycle and go to RESP when the counter is 0.
REQ-013 SHALL, in RESP, assert exactly one of ACK/ERR for exactly one cycle, then return to IDLE.
REQ-014 SHALL give a response latency of WAIT_STATES+1 cycles after the request edge (ACK high in cycle N+1+WAIT_STATES).
REQ-015 SHALL register DAT_I as mem[index] in the cycle response is high for reads.
REQ-016 SHALL hold DAT_I at its last value outside RESP (0 after reset).
REQ-017 SHALL commit a write to mem[index] on the clock edge that ends RESP, never earlier.
REQ-018 SHALL compute the byte offset as ADR minus ADR_BASE, modulo 2^32.
REQ-019 SHALL set index to offset[log2(DEPTH)+1:2] and ignore ADR[1:0].
REQ-020 SHALL treat an access as in range when offset < DEPTH*4, so wrap-around below ADR_BASE is out of range.
REQ-021 SHALL, if wb.CYC falls in WAIT or RESP, abort to IDLE on the next edge with no write committed and no ACK/ERR issued.
REQ-022 SHALL start a new transaction from IDLE when STB is still high after a response (no wait in IDLE required).
REQ-023 SHALL tie wb.RTY to 0.
REQ-024 SHALL ignore STB outside IDLE.
REQ-025 SHALL NOT reset RAM contents.

Reset
REQ-026 SHALL, on rst low, immediately force state IDLE, counter 0, ACK=0, ERR=0, RTY=0, DAT_I=32'h0, independent of clk.
REQ-027 SHALL, on reset mid-transaction, discard any pending write.
REQ-028 SHALL accept the first request on the first rising edge after rst goes high.

Configuration
REQ-029 SHALL use macro WB_RAM_SLAVE_ERR_EN.
REQ-030 SHALL, with WB_RAM_SLAVE_ERR_EN defined, answer out-of-range accesses with ERR (ACK=0) in RESP, same latency, DAT_I=0, no write.
REQ-031 SHALL, with WB_RAM_SLAVE_ERR_EN undefined, answer out-of-range accesses with ACK, DAT_I=32'h0 for reads, and drop writes; ERR stays 0.

Verification
REQ-032 SHALL verify basic write/read: defaults; write 32'hDEADBEEF to 0x1004, then read 0x1004 -> each ACK a single pulse 3 cycles after request, read DAT_I=32'hDEADBEEF.
REQ-033 SHALL verify boundaries: write/read 0x13FC -> ACK with data; access 0x1400 and 0x0FFC -> ERR with macro, ACK with DAT_I=0 without; mem[255] unchanged.
REQ-034 SHALL verify abort: write 32'h1234_5678 to 0x1008, drop CYC in WAIT -> no ACK/ERR; subsequent read of 0x1008 returns prior value.
REQ-035 SHALL verify back-to-back: hold CYC/STB high through reads of 0x1004 and 0x1008 -> ACKs in cycles N+3 and N+7, correct data each.
REQ-036 SHALL verify asynchronous reset: pull rst low mid-WAIT of a write -> ACK/ERR/DAT_I=0 without a clock edge, memory unchanged, next request ACKed at normal latency.
REQ-037 SHALL verify zero wait states: WAIT_STATES=0, read 0x1000 -> ACK in cycle N+1.
